// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data has priority; a bounded count of consecutive data wins forces a fetch grant.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        core_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        fetch_wins;

  assign fetch_wins = if_req & (~d_req | (cnt_q == LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Hold off one cycle while a completion pulse is out so the requester can move on.
        if ((if_req | d_req) && !(if_valid_q | d_valid_q)) begin
          state_d   = S_ISSUE;
          mem_req_d = 1'b1;
          if (fetch_wins) begin
            owner_d     = OWN_FETCH;
            mem_addr_d  = if_addr;
            mem_we_d    = '0;
            mem_wdata_d = '0;
            cnt_d       = '0;
          end else begin
            owner_d     = OWN_DATA;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
            if (!if_req) begin
              cnt_d = '0;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          // A requester that dropped its request was flushed: complete silently.
          if (owner_q == OWN_FETCH && if_req) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else if (owner_q == OWN_DATA && d_req) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_valid   = if_valid_q;
  assign d_valid    = d_valid_q;
  assign core_stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench: a driver plays core and memory, a monitor checks completions against a scoreboard.
module tb_unified_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_we = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        if_valid, d_valid, mem_req, core_stall;

  unified_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_fetch; logic [31:0] data; } resp_t;
  resp_t sb_q[$];
  resp_t r;

  int total = 0, bad = 0;

  // Model of the transaction in flight and of the arbitration history.
  bit          in_issue, waiting, own_fetch, exp_arb, arb_if, arb_d;
  bit          pulse_now, pulse_next, pulse_fetch_now, pulse_fetch_next;
  bit          if_flushed, d_flushed, rst_done, exp_fetch;
  int          streak, gnt_wait, rv_wait;
  logic [31:0] arb_if_addr, arb_d_addr, arb_d_wdata, t_addr, t_wdata;
  logic [3:0]  arb_d_we, t_we;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic        exp_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic sample();
    pulse_now = pulse_next;
    pulse_fetch_now = pulse_fetch_next;
    pulse_next = 0;
    if (exp_arb) begin
      check("mem_req_rise", mem_req, 1);
      // Data first, unless fetch has already been passed over LIMIT times.
      exp_fetch = arb_if && (!arb_d || streak == LIMIT);
      if (exp_fetch) streak = 0;
      else if (arb_if) streak++;
      else streak = 0;
      own_fetch = exp_fetch;
      t_addr  = exp_fetch ? arb_if_addr : arb_d_addr;
      t_we    = exp_fetch ? 4'h0 : arb_d_we;
      t_wdata = exp_fetch ? 32'h0 : arb_d_wdata;
      in_issue = 1;
      gnt_wait = ($urandom_range(9) == 0) ? 5 : $urandom_range(2);
      $display("grant %s addr=%08h we=%h wdata=%08h", exp_fetch ? "fetch" : "data ", t_addr, t_we, t_wdata);
    end else if (!in_issue && !waiting) begin
      check("idle_no_req", mem_req, 0);
    end
    if (in_issue) begin
      check("issue_req", mem_req, 1);
      check("issue_addr", mem_addr, t_addr);
      check("issue_we", mem_we, t_we);
      check("issue_wdata", mem_wdata, t_wdata);
    end else if (waiting) begin
      check("wait_req_low", mem_req, 0);
    end
  endtask

  task automatic drive_reqs(input int pct, input int fpct);
    if (if_req && if_valid) if_req = 0;
    else if (if_req && waiting && own_fetch && !if_flushed && $urandom_range(99) < fpct) begin
      if_req = 0; if_flushed = 1;
    end
    if (!if_req && !if_flushed && $urandom_range(99) < pct) begin
      if_req = 1;
      if_addr = {16'h0, 14'($urandom), 2'b00};
    end
    if (d_req && d_valid) d_req = 0;
    else if (d_req && waiting && !own_fetch && !d_flushed && $urandom_range(99) < fpct) begin
      d_req = 0; d_flushed = 1;
    end
    if (!d_req && !d_flushed && $urandom_range(99) < pct) begin
      d_req = 1;
      d_addr = {1'b1, 31'($urandom)};
      d_we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      d_wdata = $urandom;
    end
  endtask

  task automatic drive_mem();
    exp_arb = !in_issue && !waiting && !pulse_now && (if_req || d_req);
    arb_if = if_req; arb_d = d_req;
    arb_if_addr = if_addr; arb_d_addr = d_addr; arb_d_we = d_we; arb_d_wdata = d_wdata;
    mem_gnt = 0; mem_rvalid = 0;
    mem_rdata = $urandom;
    if (in_issue) begin
      if (gnt_wait == 0) begin
        mem_gnt = 1; in_issue = 0; waiting = 1;
        rv_wait = ($urandom_range(9) == 0) ? 7 : $urandom_range(3, 1);
      end else gnt_wait--;
    end else if (waiting) begin
      rv_wait--;
      if (rv_wait == 0) begin
        mem_rvalid = 1;
        if (own_fetch ? if_req : d_req) begin
          sb_q.push_back('{own_fetch, mem_rdata});
          pulse_next = 1;
          pulse_fetch_next = own_fetch;
        end else begin
          $display("flush %s rdata=%08h", own_fetch ? "fetch" : "data ", mem_rdata);
        end
        waiting = 0; if_flushed = 0; d_flushed = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("one_valid", if_valid & d_valid, 0);
      if (if_valid || d_valid) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: if_valid=%0b d_valid=%0b with no completion due", if_valid, d_valid);
        end else begin
          r = sb_q.pop_front();
          check("valid_owner", {31'b0, if_valid}, {31'b0, r.is_fetch});
          if (r.is_fetch) exp_if_rdata = r.data;
          else exp_d_rdata = r.data;
          $display("complete %s rdata=%08h", r.is_fetch ? "fetch" : "data ", r.data);
        end
      end
      check("if_rdata", if_rdata, exp_if_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      exp_stall = (if_req && !(pulse_now && pulse_fetch_now)) || (d_req && !(pulse_now && !pulse_fetch_now));
      check("core_stall", core_stall, exp_stall);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_if_valid"}, if_valid, 0);
    check({tag, "_d_valid"}, d_valid, 0);
  endtask

  initial begin
    exp_if_rdata = '0; exp_d_rdata = '0;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 0;
    for (int i = 0; i < 1400; i++) begin
      @(posedge clk);
      #1;
      sample();
      if (i >= 1000 && waiting && !rst_done) begin
        // Abandon the transaction in WAIT, then deliver its response into an idle arbiter.
        #1 reset = 1;
        #1 check_all_zero("midreset");
        if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
        in_issue = 0; waiting = 0; exp_arb = 0; pulse_next = 0; pulse_now = 0;
        if_flushed = 0; d_flushed = 0; streak = 0;
        sb_q.delete();
        exp_if_rdata = '0; exp_d_rdata = '0;
        $display("reset asserted in WAIT");
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(posedge clk); #1 mem_rvalid = 0;
        check("late_rvalid_if_valid", if_valid, 0);
        check("late_rvalid_d_valid", d_valid, 0);
        check("late_rvalid_mem_req", mem_req, 0);
        rst_done = 1;
        continue;
      end
      if (i < 300)       drive_reqs(50, 10);
      else if (i < 700)  drive_reqs(100, 0);
      else if (i < 1250) drive_reqs(30, 15);
      else               drive_reqs(0, 0);
      drive_mem();
    end
    @(posedge clk);
    #1;
    check("drain_if_req", if_req, 0);
    check("drain_d_req", d_req, 0);
    check("drain_mem_req", mem_req, 0);
    check("drain_sb_empty", sb_q.size(), 0);
    check("reset_in_wait_done", {31'b0, rst_done}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port and data (load/store) port.
- Allows one outstanding memory transaction at a time.
- Arbitrates with data priority, bounded by an anti-starvation limit for fetch.
- Returns read data and completion to the requesting side, and drives a stall output that freezes the pipeline while either port waits.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending before fetch is forced; legal 1..15.
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request level; held until if_valid
- if_addr  input  32  fetch address, word aligned, stable while if_req
- if_rdata  output  32  fetched instruction, valid with if_valid
- if_valid  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request level; held until d_valid
- d_addr  input  32  data byte address, stable while d_req
- d_we  input  4  byte write enables; 0 = load
- d_wdata  input  32  store data, pre-shifted to lanes
- d_rdata  output  32  load data, valid with d_valid
- d_valid  output  1  one-cycle data completion pulse (load or store)
- mem_req  output  1  memory request, held until mem_gnt
- mem_addr  output  32  memory address
- mem_we  output  4  memory byte enables
- mem_wdata  output  32  memory write data
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  response/ack, at least 1 cycle after mem_gnt
- mem_rdata  input  32  memory read data, valid with mem_rvalid
- core_stall  output  1  pipeline freeze

Behaviour:
- Reset (async, active-high):
  - state=IDLE, starvation counter=0, owner=NONE.
  - mem_req, mem_addr, mem_we, mem_wdata, if_rdata, d_rdata, if_valid and d_valid all 0.
  - A reset mid-transaction abandons it; a late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is pending and no valid pulse is being driven this cycle, arbitrate and go to ISSUE.
  - mem_* outputs are registered from the winner, so mem_req rises the cycle after the request is seen.
  - Stores the owner (FETCH/DATA).
- Arbitration rule:
  - Only d_req pending: data wins.
  - Only if_req pending: fetch wins.
  - Both pending: data wins unless counter==STARVE_LIMIT, in which case fetch wins.
- Starvation counter:
  - +1 on a data grant made while if_req=1 (saturating).
  - Cleared on any fetch grant, and on a data grant with if_req=0.
- Fetch grants drive mem_we=0 and mem_wdata=0.
- ISSUE: mem_req=1 with stable address and data until a cycle with mem_gnt=1; then mem_req=0 next cycle and go to WAIT.
- WAIT: on mem_rvalid, register mem_rdata into the owner's rdata and pulse the owner's valid for exactly one cycle (the cycle after rvalid). Return to IDLE; the next arbitration happens in the cycle after the valid pulse.
- Dropped requests: if the owner's req is low when mem_rvalid arrives (flush), the transaction still completes on memory, but no valid pulse is issued and rdata holds its old value.
- Store data: stores still wait for mem_rvalid (write ack); d_rdata is loaded with mem_rdata, don't-care.
- Minimum latency: req seen at cycle 0 → mem_req at 1 → gnt at 1 → rvalid at 2 → valid at 3.
- core_stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational; deasserts in the same cycle as the last pending valid.
- rdata outputs hold their last value between transactions.
- At most one of if_valid and d_valid is high in any cycle.

Test Plan:
- Fetch only: if_req=1, if_addr=0x40, gnt the same cycle as mem_req, rvalid 2 cycles after gnt with 0x00500093 → mem_addr=0x40, mem_we=0; if_valid one pulse with if_rdata=0x00500093; core_stall high until that cycle.
- Store vs fetch conflict: both req in the same cycle, d_addr=0x100, d_we=4'b1111, d_wdata=0xDEADBEEF → data issued first with those values; fetch issued after d_valid.
- Starvation, STARVE_LIMIT=4: if_req held high, d_req re-asserted back-to-back → exactly 4 data grants, then a fetch grant, then counter=0 and data resumes.
- Wait states: mem_gnt withheld 5 cycles, rvalid 7 cycles later → mem_req and mem_addr stable throughout ISSUE; single valid pulse; no second mem_req before the valid pulse.
- Flush: d_req dropped in WAIT, then mem_rvalid with 0x12345678 → no d_valid, d_rdata unchanged; the next fetch issues normally.
- Reset in WAIT: assert reset, then mem_rvalid → all outputs 0 immediately; no valid pulse; the next request after reset issues from IDLE.
